// File: rtl/axi_dma_ring_pkg.sv
// Shared types and helpers for the receive-ring descriptor generator.
package axi_dma_ring_pkg;

  // Default ring size: 2^RING_PTR_W slots; pointers carry one extra wrap bit.
  localparam int RING_PTR_W = 4;

  // Ring pointer with wrap bit. Wrap-around arithmetic comes from the natural
  // modulo-2^(N+1) behaviour of the unsigned vector.
  typedef logic [RING_PTR_W:0] ring_ptr_t;

  // Descriptor issue FSM.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Forward distance from b to a, modulo the pointer range.
  function automatic ring_ptr_t ring_dist(input ring_ptr_t a, input ring_ptr_t b);
    return ring_ptr_t'(a - b);
  endfunction

endpackage

// File: rtl/axi_dma_wr_ring_if.sv
// Descriptor request and write-status channels between the ring generator and
// the DMA write engine.
interface axi_dma_wr_ring_if #(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 20,
  parameter int TAG_WIDTH      = 8
);

  logic [AXI_ADDR_WIDTH-1:0] m_axis_write_desc_addr;
  logic [LEN_WIDTH-1:0]      m_axis_write_desc_len;
  logic [TAG_WIDTH-1:0]      m_axis_write_desc_tag;
  logic                      m_axis_write_desc_valid;
  logic                      m_axis_write_desc_ready;

  logic [LEN_WIDTH-1:0]      s_axis_write_desc_status_len;
  logic [TAG_WIDTH-1:0]      s_axis_write_desc_status_tag;
  logic                      s_axis_write_desc_status_valid;

  // Ring generator side: issues descriptors, consumes status.
  modport master (
    output m_axis_write_desc_addr,
    output m_axis_write_desc_len,
    output m_axis_write_desc_tag,
    output m_axis_write_desc_valid,
    input  m_axis_write_desc_ready,
    input  s_axis_write_desc_status_len,
    input  s_axis_write_desc_status_tag,
    input  s_axis_write_desc_status_valid
  );

  // DMA side: accepts descriptors, produces status.
  modport slave (
    input  m_axis_write_desc_addr,
    input  m_axis_write_desc_len,
    input  m_axis_write_desc_tag,
    input  m_axis_write_desc_valid,
    output m_axis_write_desc_ready,
    output s_axis_write_desc_status_len,
    output s_axis_write_desc_status_tag,
    output s_axis_write_desc_status_valid
  );

endinterface

// File: rtl/axi_dma_wr_ring.sv
// Receive-ring descriptor generator: issues one write descriptor per ring
// slot, retires slots in order from the DMA status stream and stalls when
// software has not yet released slots through the consumer pointer.
// RING_PTR_WIDTH must match axi_dma_ring_pkg::RING_PTR_W (pointer type).
module axi_dma_wr_ring
  import axi_dma_ring_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 20,
  parameter int TAG_WIDTH      = 8,
  parameter int RING_PTR_WIDTH = RING_PTR_W,
  parameter int SLOT_SIZE      = 2048
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [AXI_ADDR_WIDTH-1:0] ring_base_addr,
  input  logic [RING_PTR_WIDTH:0]   cons_ptr,
  input  logic                      cons_ptr_valid,
  axi_dma_wr_ring_if.master         dma,
  output logic [RING_PTR_WIDTH:0]   prod_ptr,
  output logic [RING_PTR_WIDTH:0]   head_ptr,
  output logic                      cpl_valid,
  output logic [LEN_WIDTH-1:0]      cpl_len,
  output logic                      full,
  output logic                      busy,
  output logic                      error
);

  localparam int        SLOT_SHIFT = $clog2(SLOT_SIZE);
  localparam int        SLOT_COUNT = 1 << RING_PTR_WIDTH;
  localparam ring_ptr_t RING_SPAN  = ring_ptr_t'(SLOT_COUNT);

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] desc_addr_q, desc_addr_d;
  logic [LEN_WIDTH-1:0]      desc_len_q, desc_len_d;
  logic [TAG_WIDTH-1:0]      desc_tag_q, desc_tag_d;
  logic                      desc_valid_q, desc_valid_d;
  ring_ptr_t                 head_q, head_d;
  ring_ptr_t                 prod_q, prod_d;
  ring_ptr_t                 tail_q, tail_d;
  logic                      cpl_valid_q, cpl_valid_d;
  logic [LEN_WIDTH-1:0]      cpl_len_q, cpl_len_d;
  logic                      full_q, full_d;
  logic                      busy_q, busy_d;
  logic                      error_q, error_d;

  logic [AXI_ADDR_WIDTH-1:0] slot_off_s;
  logic                      full_now_s;
  ring_ptr_t                 cons_s;
  logic [RING_PTR_WIDTH-1:0] stat_slot_s;

  // Only the slot-index bits of the returned tag are meaningful.
  logic unused_tag_hi_s;
  assign unused_tag_hi_s = ^dma.s_axis_write_desc_status_tag[TAG_WIDTH-1:RING_PTR_WIDTH];

  assign cons_s      = ring_ptr_t'(cons_ptr);
  assign stat_slot_s = dma.s_axis_write_desc_status_tag[RING_PTR_WIDTH-1:0];

  // Issue FSM, status retirement, consumer update and status flag next-state.
  always_comb begin
    state_d      = state_q;
    desc_addr_d  = desc_addr_q;
    desc_len_d   = desc_len_q;
    desc_tag_d   = desc_tag_q;
    desc_valid_d = desc_valid_q;
    head_d       = head_q;
    prod_d       = prod_q;
    tail_d       = tail_q;
    cpl_valid_d  = 1'b0;
    cpl_len_d    = cpl_len_q;
    error_d      = error_q;

    slot_off_s = AXI_ADDR_WIDTH'(head_q[RING_PTR_WIDTH-1:0]) << SLOT_SHIFT;
    // Registered pointers only: a slot freed this cycle is usable next cycle.
    full_now_s = (ring_dist(head_q, tail_q) == RING_SPAN);

    case (state_q)
      IDLE: begin
        if (enable && !full_now_s) begin
          desc_addr_d  = ring_base_addr + slot_off_s;
          desc_len_d   = LEN_WIDTH'(SLOT_SIZE);
          desc_tag_d   = TAG_WIDTH'(head_q[RING_PTR_WIDTH-1:0]);
          desc_valid_d = 1'b1;
          state_d      = ISSUE;
        end else begin
          desc_valid_d = 1'b0;
        end
      end
      ISSUE: begin
        // A pending descriptor is never withdrawn, even if enable drops.
        if (dma.m_axis_write_desc_ready) begin
          head_d       = ring_ptr_t'(head_q + 1'b1);
          desc_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          desc_valid_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      default: begin
        desc_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase

    // Status retires slots strictly in order; a wrong tag is flagged but
    // still retires the expected slot so the ring keeps moving.
    if (dma.s_axis_write_desc_status_valid) begin
      if (prod_q != head_q) begin
        if (stat_slot_s != prod_q[RING_PTR_WIDTH-1:0]) begin
          error_d = 1'b1;
        end else begin
          error_d = error_q;
        end
        prod_d      = ring_ptr_t'(prod_q + 1'b1);
        cpl_valid_d = 1'b1;
        cpl_len_d   = dma.s_axis_write_desc_status_len;
      end else begin
        error_d = 1'b1;
      end
    end else begin
      prod_d = prod_q;
    end

    // Software may only release slots that have already completed.
    if (cons_ptr_valid) begin
      if (ring_dist(cons_s, tail_q) <= ring_dist(prod_q, tail_q)) begin
        tail_d = cons_s;
      end else begin
        error_d = 1'b1;
      end
    end else begin
      tail_d = tail_q;
    end

    full_d = (ring_dist(head_d, tail_d) == RING_SPAN);
    busy_d = (head_d != prod_d) || desc_valid_d;
  end

  // State, descriptor and pointer registers; reset restarts the ring at slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
      desc_tag_q   <= '0;
      desc_valid_q <= 1'b0;
      head_q       <= '0;
      prod_q       <= '0;
      tail_q       <= '0;
      cpl_valid_q  <= 1'b0;
      cpl_len_q    <= '0;
      full_q       <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      desc_addr_q  <= desc_addr_d;
      desc_len_q   <= desc_len_d;
      desc_tag_q   <= desc_tag_d;
      desc_valid_q <= desc_valid_d;
      head_q       <= head_d;
      prod_q       <= prod_d;
      tail_q       <= tail_d;
      cpl_valid_q  <= cpl_valid_d;
      cpl_len_q    <= cpl_len_d;
      full_q       <= full_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign dma.m_axis_write_desc_addr  = desc_addr_q;
  assign dma.m_axis_write_desc_len   = desc_len_q;
  assign dma.m_axis_write_desc_tag   = desc_tag_q;
  assign dma.m_axis_write_desc_valid = desc_valid_q;

  assign prod_ptr  = prod_q;
  assign head_ptr  = head_q;
  assign cpl_valid = cpl_valid_q;
  assign cpl_len   = cpl_len_q;
  assign full      = full_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_axi_dma_wr_ring.sv
// Directed self-checking bench for axi_dma_wr_ring (default parameters,
// ring base 0x1000, 2048-byte slots, 16 slots).
module tb_axi_dma_wr_ring;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] base;
  logic [4:0]  cons_ptr;
  logic        cons_valid;
  logic [4:0]  prod_ptr;
  logic [4:0]  head_ptr;
  logic        cpl_valid;
  logic [19:0] cpl_len;
  logic        full;
  logic        busy;
  logic        error;

  int total = 0;
  int bad   = 0;

  axi_dma_wr_ring_if dma_if ();

  axi_dma_wr_ring dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .ring_base_addr (base),
    .cons_ptr       (cons_ptr),
    .cons_ptr_valid (cons_valid),
    .dma            (dma_if),
    .prod_ptr       (prod_ptr),
    .head_ptr       (head_ptr),
    .cpl_valid      (cpl_valid),
    .cpl_len        (cpl_len),
    .full           (full),
    .busy           (busy),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a valid descriptor and check its fields against slot.
  task automatic expect_desc(input string tag, input int slot);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dma_if.m_axis_write_desc_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_wait"}, 32'(ok), 32'd1);
    check({tag, "_addr"}, 32'(dma_if.m_axis_write_desc_addr), 32'h1000 + 32'(slot) * 32'h800);
    check({tag, "_tag"}, 32'(dma_if.m_axis_write_desc_tag), 32'(slot));
    check({tag, "_len"}, 32'(dma_if.m_axis_write_desc_len), 32'd2048);
  endtask

  // Count descriptors accepted over a fixed cycle window.
  task automatic count_accepts(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (dma_if.m_axis_write_desc_valid === 1'b1 && dma_if.m_axis_write_desc_ready === 1'b1) n++;
      tick();
    end
  endtask

  task automatic status(input logic [7:0] tag);
    dma_if.s_axis_write_desc_status_tag   = tag;
    dma_if.s_axis_write_desc_status_len   = 20'd64;
    dma_if.s_axis_write_desc_status_valid = 1'b1;
    tick();
    dma_if.s_axis_write_desc_status_valid = 1'b0;
  endtask

  task automatic cons(input logic [4:0] p);
    cons_ptr   = p;
    cons_valid = 1'b1;
    tick();
    cons_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    cons_valid = 1'b0;
    dma_if.m_axis_write_desc_ready = 1'b0;
    dma_if.s_axis_write_desc_status_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    enable = 1'b0;
    base = 16'h1000;
    cons_ptr = 5'd0;
    cons_valid = 1'b0;
    dma_if.m_axis_write_desc_ready = 1'b0;
    dma_if.s_axis_write_desc_status_len = 20'd0;
    dma_if.s_axis_write_desc_status_tag = 8'd0;
    dma_if.s_axis_write_desc_status_valid = 1'b0;
    tick();
    // Reset state.
    check("rst_valid", 32'(dma_if.m_axis_write_desc_valid), 32'd0);
    check("rst_head", 32'(head_ptr), 32'd0);
    check("rst_prod", 32'(prod_ptr), 32'd0);
    check("rst_flags", {29'd0, full, busy, error}, 32'd0);
    check("rst_cpl", 32'(cpl_valid), 32'd0);
    tick();
    rst_n = 1'b1;

    // Basic: three descriptors, ready always high.
    enable = 1'b1;
    dma_if.m_axis_write_desc_ready = 1'b1;
    expect_desc("basic0", 0);
    tick();
    expect_desc("basic1", 1);
    tick();
    expect_desc("basic2", 2);
    enable = 1'b0;
    tick();
    check("basic_head", 32'(head_ptr), 32'd3);
    check("basic_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      status(8'(k));
      check("basic_cpl_valid", 32'(cpl_valid), 32'd1);
      check("basic_cpl_len", 32'(cpl_len), 32'd64);
      check("basic_prod", 32'(prod_ptr), 32'(k + 1));
    end
    tick();
    check("basic_cpl_clear", 32'(cpl_valid), 32'd0);
    check("basic_idle_busy", 32'(busy), 32'd0);
    check("basic_err", 32'(error), 32'd0);

    // Full: 13 more fill the 16-slot ring, then cons_ptr=3 frees 3 slots.
    enable = 1'b1;
    count_accepts(60, n);
    check("full_count", 32'(n), 32'd13);
    check("full_head", 32'(head_ptr), 32'h10);
    check("full_flag", 32'(full), 32'd1);
    check("full_valid", 32'(dma_if.m_axis_write_desc_valid), 32'd0);
    cons(5'd3);
    check("full_release", 32'(full), 32'd0);
    count_accepts(30, n);
    check("full_more", 32'(n), 32'd3);
    check("full_head2", 32'(head_ptr), 32'h13);
    check("full_flag2", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) status(8'((3 + i) % 16));
    check("drain_prod", 32'(prod_ptr), 32'h13);
    check("drain_err", 32'(error), 32'd0);
    enable = 1'b0;
    dma_if.m_axis_write_desc_ready = 1'b0;
    tick();
    check("drain_busy", 32'(busy), 32'd0);
    cons(5'h13);
    check("drain_full", 32'(full), 32'd0);

    // Backpressure: descriptor for slot 3 held for 10 cycles, enable dropped.
    enable = 1'b1;
    expect_desc("bp", 3);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) enable = 1'b0;
      tick();
      check("bp_valid", 32'(dma_if.m_axis_write_desc_valid), 32'd1);
      check("bp_addr", 32'(dma_if.m_axis_write_desc_addr), 32'h2800);
      check("bp_tag", 32'(dma_if.m_axis_write_desc_tag), 32'd3);
      check("bp_head", 32'(head_ptr), 32'h13);
    end
    dma_if.m_axis_write_desc_ready = 1'b1;
    tick();
    check("bp_head_adv", 32'(head_ptr), 32'h14);
    check("bp_valid_drop", 32'(dma_if.m_axis_write_desc_valid), 32'd0);
    tick();
    check("bp_no_reissue", 32'(dma_if.m_axis_write_desc_valid), 32'd0);
    status(8'd3);
    check("bp_prod", 32'(prod_ptr), 32'h14);
    cons(5'h14);

    // Wrap: 40 slots with prompt status and consumer updates.
    for (int i = 0; i < 40; i++) begin
      enable = 1'b1;
      expect_desc("wrap", (20 + i) % 16);
      enable = 1'b0;
      tick();
      status(8'((20 + i) % 16));
      check("wrap_cpl", 32'(cpl_valid), 32'd1);
      check("wrap_prod", 32'(prod_ptr), 32'((21 + i) % 32));
      cons(5'((21 + i) % 32));
    end
    check("wrap_head", 32'(head_ptr), 32'd28);
    check("wrap_err", 32'(error), 32'd0);

    // Async reset while a descriptor is pending.
    enable = 1'b1;
    dma_if.m_axis_write_desc_ready = 1'b0;
    expect_desc("pre_rst", 12);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(dma_if.m_axis_write_desc_valid), 32'd0);
    check("arst_addr", 32'(dma_if.m_axis_write_desc_addr), 32'd0);
    check("arst_ptrs", {22'd0, head_ptr, prod_ptr}, 32'd0);
    check("arst_flags", {28'd0, full, busy, error, cpl_valid}, 32'd0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    enable = 1'b1;
    dma_if.m_axis_write_desc_ready = 1'b1;
    expect_desc("post_rst", 0);
    enable = 1'b0;
    status(8'd12);
    check("stale_err", 32'(error), 32'd1);
    check("stale_prod", 32'(prod_ptr), 32'd0);
    check("stale_head", 32'(head_ptr), 32'd1);

    // Error: tag 5 returned while slot 2 expected; prod still advances.
    do_reset();
    enable = 1'b1;
    dma_if.m_axis_write_desc_ready = 1'b1;
    expect_desc("ea0", 0);
    tick();
    expect_desc("ea1", 1);
    tick();
    expect_desc("ea2", 2);
    enable = 1'b0;
    tick();
    status(8'd0);
    status(8'd1);
    check("ea_clean", 32'(error), 32'd0);
    status(8'd5);
    check("ea_err", 32'(error), 32'd1);
    check("ea_prod", 32'(prod_ptr), 32'd3);
    check("ea_cpl", 32'(cpl_valid), 32'd1);

    // Error: status with nothing in flight is ignored.
    do_reset();
    status(8'd0);
    check("eb_err", 32'(error), 32'd1);
    check("eb_prod", 32'(prod_ptr), 32'd0);
    check("eb_cpl", 32'(cpl_valid), 32'd0);

    // Error: consumer pointer beyond prod is rejected and tail stays at 0.
    do_reset();
    enable = 1'b1;
    dma_if.m_axis_write_desc_ready = 1'b1;
    expect_desc("ec0", 0);
    tick();
    expect_desc("ec1", 1);
    enable = 1'b0;
    tick();
    status(8'd0);
    cons(5'd2);
    check("ec_err", 32'(error), 32'd1);
    enable = 1'b1;
    count_accepts(60, n);
    check("ec_fill", 32'(n), 32'd14);
    check("ec_head", 32'(head_ptr), 32'h10);
    check("ec_full", 32'(full), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_dma_wr_ring.md
# axi_dma_wr_ring

Receive-ring descriptor generator placed directly upstream of `axi_dma_wr`.
- Issues one write descriptor per fixed-size slot of a power-of-two host ring: address = base + slot × SLOT_SIZE, length = SLOT_SIZE, tag = slot index.
- Retires slots in order from the DMA's write-status stream.
- Publishes producer/in-flight pointers and stalls when software has not yet freed slots via the consumer pointer.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 16, host address width; matches `axi_dma_wr`.
- LEN_WIDTH, 20, descriptor length width; matches `axi_dma_wr`.
- TAG_WIDTH, 8, descriptor tag width; must be ≥ RING_PTR_WIDTH.
- RING_PTR_WIDTH, 4, log2 of ring slot count (16 slots).
- SLOT_SIZE, 2048, bytes per slot; power of two, < 2^LEN_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  allow new descriptors to be issued.
- ring_base_addr  in  AXI_ADDR_WIDTH  ring base; SLOT_SIZE-aligned, stable while busy.
- cons_ptr  in  RING_PTR_WIDTH+1  software consumer pointer, with wrap bit.
- cons_ptr_valid  in  1  single-cycle strobe that loads cons_ptr.
- m_axis_write_desc_addr  out  AXI_ADDR_WIDTH  slot address.
- m_axis_write_desc_len  out  LEN_WIDTH  always SLOT_SIZE.
- m_axis_write_desc_tag  out  TAG_WIDTH  slot index, zero-extended.
- m_axis_write_desc_valid  out  1  descriptor valid.
- m_axis_write_desc_ready  in  1  DMA accepts.
- s_axis_write_desc_status_len  in  LEN_WIDTH  bytes written.
- s_axis_write_desc_status_tag  in  TAG_WIDTH  completed tag.
- s_axis_write_desc_status_valid  in  1  status strobe; no ready.
- prod_ptr  out  RING_PTR_WIDTH+1  completed-slot pointer.
- head_ptr  out  RING_PTR_WIDTH+1  issued-slot pointer.
- cpl_valid  out  1  one-cycle pulse per retired slot.
- cpl_len  out  LEN_WIDTH  length of the retired slot.
- full  out  1  head − tail == 2^RING_PTR_WIDTH.
- busy  out  1  head ≠ prod, or descriptor pending.
- error  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
Pointers:
- head, prod and tail are RING_PTR_WIDTH+1 bits wide, with modulo wrap.
- Invariant: tail ≤ prod ≤ head ≤ tail + 2^N, in modular distance.

FSM states:
- IDLE
  - If enable && !full: load addr = ring_base_addr + head[N-1:0]·SLOT_SIZE, tag = head[N-1:0].
  - Assert valid and go to ISSUE.
- ISSUE
  - Hold addr/len/tag/valid stable until ready.
  - On valid&&ready: head++, deassert valid, return to IDLE.
  - Deasserting enable does not withdraw a pending descriptor.

Status path:
- On status_valid with prod ≠ head:
  - If tag[N-1:0] ≠ prod[N-1:0], set error.
  - prod++ regardless.
  - cpl_valid=1 and cpl_len=status_len on the next cycle.
- On status_valid with prod == head: set error, ignore the status.

Consumer updates:
- On cons_ptr_valid: accept if (cons_ptr − tail) ≤ (prod − tail), modular; else set error and keep tail.

Simultaneous events:
- Issue, status and cons update may all occur in one cycle; each pointer has a single writer.
- full is computed from the registered head/tail; a slot freed this cycle becomes usable next cycle.

Arithmetic:
- Slot offset = head[N-1:0] << log2(SLOT_SIZE), truncated to AXI_ADDR_WIDTH.
- Address wraps silently.

## Timing
- Reset: all pointers 0, FSM IDLE, every output 0 (including m_axis_write_desc_valid, cpl_valid, full, busy, error).
- Issue latency: enable high with space → valid asserted 1 cycle later. Max rate is one descriptor per 2 cycles (IDLE→ISSUE→IDLE).
- Status → prod_ptr/cpl_valid update: 1 cycle.
- cons_ptr_valid → full deassert: 1 cycle.
- Reset mid-transfer: all state is dropped immediately and the ring restarts at slot 0. In-flight DMA status after reset counts as spurious and sets error.

## Structure
- Shared package `axi_dma_ring_pkg`:
  - ring pointer type, parameterised by RING_PTR_WIDTH;
  - modular-distance function `ring_dist(a,b)`;
  - FSM state enum {IDLE, ISSUE}.
- Single module, no sub-module. The descriptor register is the only buffering; the status path needs none because status is strobe-only.

## Test plan
- Basic: base=0x1000, SLOT_SIZE=2048, enable, ready always high → descriptors at addr 0x1000, 0x1800, 0x2000… with tag 0,1,2… Each status (len=64, tag=k) → cpl_valid pulse with cpl_len=64, prod_ptr=k+1.
- Full: no cons updates → exactly 16 descriptors issued, full=1, valid stays 0. cons_ptr=3 strobe → exactly 3 further descriptors issued.
- Backpressure: ready low for 10 cycles → addr/tag/valid held constant; head_ptr advances only on the ready cycle. Dropping enable mid-ISSUE still completes that descriptor.
- Wrap: run 40 slots with prompt status and cons updates → tag wraps 15→0, address wraps to the base, head_ptr wrap bit toggles, error=0.
- Errors: status with tag 5 while tag 2 expected → error=1 and prod still advances. Status with prod==head → error=1, prod unchanged. cons_ptr beyond prod → error=1, tail unchanged.
- Async reset asserted mid-ISSUE → all outputs 0 immediately; after release, the next descriptor addr equals the base.
